pipeline_hazard_unit: RTL and testbench
=======================================

// Module: pipeline_hazard_unit
// PURPOSE
//  Hazard and forwarding controller for the parametrised pipeline (ID -> EX -> MEM -> WB).
//  Keeps a shadow pipeline of per-instruction control state: valid, dst, wb, mem_read.
//  Generates registered EX-stage forwarding selects, a one-cycle load-use stall and jump flushes.
//  Keeps saturating stall and flush counters for bring-up.
//  Sits beside the decode stage. Drives IF/ID hold, the ID->EX bubble, the ALU operand muxes and the regfile write port.
// PARAMETERS
//  REG_AW   3   register address width (2**REG_AW architectural registers, all writable)
//  CNT_W   16   width of the stall_count and flush_count counters
// PORTS
//  clk             in   1       rising-edge clock
//  reset           in   1       synchronous, active-high; clears all state on the edge it is sampled
//  id_valid        in   1       ID holds a real instruction
//  id_src1/id_src2 in   REG_AW  source register addresses
//  id_src1_used/id_src2_used in 1  operand is actually read
//  id_dst          in   REG_AW  destination register
//  id_wb           in   1       instruction writes the register file
//  id_mem_read     in   1       instruction is a load (result is available only after MEM)
//  jump_taken      in   1       jump resolved taken this cycle (EX-stage decision)
//  stall           out  1       comb: hold PC and IF/ID, insert a bubble into EX
//  flush_id        out  1       comb: squash the IF/ID contents (equals jump_taken)
//  fwd1_sel/fwd2_sel out 2      reg, aligned with EX: 00 regfile, 01 MEM-stage ALU result, 10 WB value, 11 never driven
//  ex_valid/mem_valid/wb_valid out 1  shadow stage valids
//  wb_en           out  1       wb_valid & wb flag of the WB-stage entry
//  wb_dst          out  REG_AW  destination of the WB-stage entry
//  stall_count     out  CNT_W   saturating count of stall cycles
//  flush_count     out  CNT_W   saturating count of flush cycles
// BEHAVIOUR
//  Reset:
//   - all valids, fwd selects, wb_en, wb_dst and both counters are 0 after the edge.
//   - stall and flush_id follow their comb equations; no entry is valid, so stall = 0.
//   - reset mid-stream discards every in-flight entry; no write-enable leaks out.
//  Shadow pipeline: each edge EX->MEM->WB shifts unconditionally. EX loads the ID entry if id_valid & !stall & !jump_taken, else a bubble (valid = 0).
//  Load-use hazard:
//   - stall = id_valid & !jump_taken & ex_valid & ex_wb & ex_mem_read & (src1 hit | src2 hit).
//   - a hit is srcN_used & id_srcN == ex_dst.
//   - it lasts exactly 1 cycle: next cycle the load is in MEM, and the consumer is forwarded via 10 when it enters EX.
//  Forwarding selects:
//   - computed for the ID instruction and registered into fwdN_sel when it enters EX; 00 when a bubble enters.
//   - producer in EX (ex_valid & ex_wb & !ex_mem_read & dst match) -> 01.
//   - else producer in MEM (mem_valid & mem_wb & dst match, load or ALU) -> 10.
//   - else 00; a producer already in WB is covered by the regfile write-through, not forwarded.
//   - the youngest producer wins when both EX and MEM match.
//   - an unused operand always gets 00.
//  Jump: jump_taken -> flush_id = 1 and stall forced 0, same cycle; the ID instruction becomes a bubble. Jump has priority over stall.
//  Counters: stall_count += 1 per cycle with stall = 1; flush_count += 1 per cycle with jump_taken = 1. Both saturate at 2**CNT_W-1, no wrap.
//  No X on outputs at any time after the first reset.
// TESTING
//  1. ALU R1<-x, next cycle ADD reading R1 as src1 -> stall = 0; fwd1_sel = 01 when consumer in EX.
//  2. ALU writes R2, one bubble, consumer reads R2 as src2 -> fwd2_sel = 10, fwd1_sel = 00.
//  3. LOAD R3, then ADD R3 -> stall = 1 for exactly 1 cycle.
//     Next: ex_valid = 0 bubble; then the consumer in EX with fwd1_sel = 10; stall_count = 1.
//  4. EX and MEM both write R4, consumer reads R4 -> fwd1_sel = 01.
//     src1_used = 0 with a matching address -> 00.
//  5. Load-use and jump_taken in the same cycle -> stall = 0, flush_id = 1.
//     Next cycle ex_valid = 0; flush_count = 1; stall_count unchanged.
//  6. Reset with 3 entries in flight -> next edge all valids/wb_en/counters 0.
//     With CNT_W = 4, 20 stall cycles -> stall_count = 15.

Source files
------------

// File: rtl/pipeline_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_unit
// Description : Load-use stall, jump flush and registered EX-stage operand
//               forwarding selects, driven by a shadow EX/MEM/WB pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_unit #(
    parameter int REG_AW = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_src1,
    input  logic [REG_AW-1:0] id_src2,
    input  logic              id_src1_used,
    input  logic              id_src2_used,
    input  logic [REG_AW-1:0] id_dst,
    input  logic              id_wb,
    input  logic              id_mem_read,
    input  logic              jump_taken,
    output logic              stall,
    output logic              flush_id,
    output logic [1:0]        fwd1_sel,
    output logic [1:0]        fwd2_sel,
    output logic              ex_valid,
    output logic              mem_valid,
    output logic              wb_valid,
    output logic              wb_en,
    output logic [REG_AW-1:0] wb_dst,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);

    localparam logic [1:0]       c_FWD_RF  = 2'b00;
    localparam logic [1:0]       c_FWD_MEM = 2'b01;
    localparam logic [1:0]       c_FWD_WB  = 2'b10;
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic              r_ex_valid, r_ex_wb, r_ex_mem_read;
    logic [REG_AW-1:0] r_ex_dst;
    logic              r_mem_valid, r_mem_wb;
    logic [REG_AW-1:0] r_mem_dst;
    logic              r_wb_valid, r_wb_wb;
    logic [REG_AW-1:0] r_wb_dst;
    logic [1:0]        r_fwd1, r_fwd2;
    logic [CNT_W-1:0]  r_stall_cnt, r_flush_cnt;

    logic              w_hit1, w_hit2, w_stall, w_issue;
    logic              w_ex_fwd_ok, w_mem_fwd_ok;
    logic [1:0]        w_fwd1, w_fwd2;

    // A load still in EX cannot be forwarded; MEM-stage producers may be either kind.
    function automatic logic [1:0] f_fwd_sel(
        input logic              used,
        input logic [REG_AW-1:0] src,
        input logic              ex_ok,
        input logic [REG_AW-1:0] ex_dst,
        input logic              mem_ok,
        input logic [REG_AW-1:0] mem_dst
    );
        logic [1:0] sel;
        sel = c_FWD_RF;
        if (used && ex_ok && (src == ex_dst))
            sel = c_FWD_MEM;
        else if (used && mem_ok && (src == mem_dst))
            sel = c_FWD_WB;
        return sel;
    endfunction

    always_comb begin
        w_hit1       = id_src1_used && (id_src1 == r_ex_dst);
        w_hit2       = id_src2_used && (id_src2 == r_ex_dst);
        w_stall      = id_valid && !jump_taken && r_ex_valid && r_ex_wb &&
                       r_ex_mem_read && (w_hit1 || w_hit2);
        w_issue      = id_valid && !w_stall && !jump_taken;
        w_ex_fwd_ok  = r_ex_valid && r_ex_wb && !r_ex_mem_read;
        w_mem_fwd_ok = r_mem_valid && r_mem_wb;
        w_fwd1       = f_fwd_sel(id_src1_used, id_src1, w_ex_fwd_ok, r_ex_dst,
                                 w_mem_fwd_ok, r_mem_dst);
        w_fwd2       = f_fwd_sel(id_src2_used, id_src2, w_ex_fwd_ok, r_ex_dst,
                                 w_mem_fwd_ok, r_mem_dst);
    end

    // Bubbles carry zeroed control fields so wb_dst/wb_en stay deterministic.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ex_valid    <= 1'b0;
            r_ex_wb       <= 1'b0;
            r_ex_mem_read <= 1'b0;
            r_ex_dst      <= '0;
            r_mem_valid   <= 1'b0;
            r_mem_wb      <= 1'b0;
            r_mem_dst     <= '0;
            r_wb_valid    <= 1'b0;
            r_wb_wb       <= 1'b0;
            r_wb_dst      <= '0;
            r_fwd1        <= c_FWD_RF;
            r_fwd2        <= c_FWD_RF;
            r_stall_cnt   <= '0;
            r_flush_cnt   <= '0;
        end else begin
            r_ex_valid    <= w_issue;
            r_ex_wb       <= w_issue && id_wb;
            r_ex_mem_read <= w_issue && id_mem_read;
            r_ex_dst      <= w_issue ? id_dst : '0;
            r_fwd1        <= w_issue ? w_fwd1 : c_FWD_RF;
            r_fwd2        <= w_issue ? w_fwd2 : c_FWD_RF;
            r_mem_valid   <= r_ex_valid;
            r_mem_wb      <= r_ex_wb;
            r_mem_dst     <= r_ex_dst;
            r_wb_valid    <= r_mem_valid;
            r_wb_wb       <= r_mem_wb;
            r_wb_dst      <= r_mem_dst;
            if (w_stall && (r_stall_cnt != c_CNT_MAX))
                r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
            if (jump_taken && (r_flush_cnt != c_CNT_MAX))
                r_flush_cnt <= r_flush_cnt + c_CNT_ONE;
        end
    end

    assign stall       = w_stall;
    assign flush_id    = jump_taken;
    assign fwd1_sel    = r_fwd1;
    assign fwd2_sel    = r_fwd2;
    assign ex_valid    = r_ex_valid;
    assign mem_valid   = r_mem_valid;
    assign wb_valid    = r_wb_valid;
    assign wb_en       = r_wb_valid && r_wb_wb;
    assign wb_dst      = r_wb_dst;
    assign stall_count = r_stall_cnt;
    assign flush_count = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_unit
// Description : Directed vector table plus hand sequences for reset and
//               counter saturation of pipeline_hazard_unit (CNT_W = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_unit;

    localparam int REG_AW = 3;
    localparam int CNT_W  = 4;
    localparam int NVEC   = 13;

    logic              clk = 1'b0;
    logic              reset;
    logic              id_valid;
    logic [REG_AW-1:0] id_src1, id_src2, id_dst;
    logic              id_src1_used, id_src2_used, id_wb, id_mem_read, jump_taken;
    logic              stall, flush_id, ex_valid, mem_valid, wb_valid, wb_en;
    logic [1:0]        fwd1_sel, fwd2_sel;
    logic [REG_AW-1:0] wb_dst;
    logic [CNT_W-1:0]  stall_count, flush_count;

    int total = 0;
    int bad   = 0;

    pipeline_hazard_unit #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_src1(id_src1), .id_src2(id_src2),
        .id_src1_used(id_src1_used), .id_src2_used(id_src2_used),
        .id_dst(id_dst), .id_wb(id_wb), .id_mem_read(id_mem_read),
        .jump_taken(jump_taken), .stall(stall), .flush_id(flush_id),
        .fwd1_sel(fwd1_sel), .fwd2_sel(fwd2_sel),
        .ex_valid(ex_valid), .mem_valid(mem_valid), .wb_valid(wb_valid),
        .wb_en(wb_en), .wb_dst(wb_dst),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [2:0] s1;
        logic       s1u;
        logic [2:0] s2;
        logic       s2u;
        logic [2:0] d;
        logic       wb;
        logic       mr;
        logic       jmp;
        logic       e_stall;
        logic       e_flush;
        logic [1:0] e_f1;
        logic [1:0] e_f2;
        logic       e_exv;
        logic       e_memv;
        logic       e_wbv;
        logic       e_wben;
        logic [2:0] e_wbdst;
        int         e_sc;
        int         e_fc;
    } vec_t;

    vec_t vecs[NVEC];

    function automatic vec_t mk(
        input logic v, input logic [2:0] s1, input logic s1u,
        input logic [2:0] s2, input logic s2u, input logic [2:0] d,
        input logic wb, input logic mr, input logic jmp,
        input logic st, input logic fl, input logic [1:0] f1, input logic [1:0] f2,
        input logic exv, input logic memv, input logic wbv, input logic wben,
        input logic [2:0] wbdst, input int sc, input int fc);
        vec_t r;
        r.v = v; r.s1 = s1; r.s1u = s1u; r.s2 = s2; r.s2u = s2u; r.d = d;
        r.wb = wb; r.mr = mr; r.jmp = jmp; r.e_stall = st; r.e_flush = fl;
        r.e_f1 = f1; r.e_f2 = f2; r.e_exv = exv; r.e_memv = memv; r.e_wbv = wbv;
        r.e_wben = wben; r.e_wbdst = wbdst; r.e_sc = sc; r.e_fc = fc;
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] s1, input logic s1u,
                         input logic [2:0] s2, input logic s2u, input logic [2:0] d,
                         input logic wb, input logic mr, input logic jmp);
        id_valid = v; id_src1 = s1; id_src1_used = s1u; id_src2 = s2;
        id_src2_used = s2u; id_dst = d; id_wb = wb; id_mem_read = mr;
        jump_taken = jmp;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_clear(input string tag);
        chk({tag, " ex_valid"}, int'(ex_valid), 0);
        chk({tag, " mem_valid"}, int'(mem_valid), 0);
        chk({tag, " wb_valid"}, int'(wb_valid), 0);
        chk({tag, " wb_en"}, int'(wb_en), 0);
        chk({tag, " wb_dst"}, int'(wb_dst), 0);
        chk({tag, " fwd1"}, int'(fwd1_sel), 0);
        chk({tag, " fwd2"}, int'(fwd2_sel), 0);
        chk({tag, " stall_count"}, int'(stall_count), 0);
        chk({tag, " flush_count"}, int'(flush_count), 0);
    endtask

    initial begin
        //                v s1 u s2 u d wb mr j | st fl f1 f2 ex me wb en wd sc fc
        vecs[0]  = mk(1, 0, 0, 0, 0, 1, 1, 0, 0,  0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(1, 1, 1, 5, 1, 6, 1, 0, 0,  0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0);
        vecs[2]  = mk(1, 0, 0, 0, 0, 2, 1, 0, 0,  0, 0, 0, 0, 1, 1, 1, 1, 1, 0, 0);
        vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 1, 1, 6, 0, 0);
        vecs[4]  = mk(1, 7, 1, 2, 1, 3, 0, 0, 0,  0, 0, 0, 2, 1, 0, 1, 1, 2, 0, 0);
        vecs[5]  = mk(1, 0, 0, 0, 0, 3, 1, 1, 0,  0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        vecs[6]  = mk(1, 3, 1, 1, 1, 4, 1, 0, 0,  1, 0, 0, 0, 0, 1, 1, 0, 3, 1, 0);
        vecs[7]  = mk(1, 3, 1, 1, 1, 4, 1, 0, 0,  0, 0, 2, 0, 1, 0, 1, 1, 3, 1, 0);
        vecs[8]  = mk(1, 0, 0, 0, 0, 4, 1, 0, 0,  0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0);
        vecs[9]  = mk(1, 4, 1, 4, 0, 5, 1, 0, 0,  0, 0, 1, 0, 1, 1, 1, 1, 4, 1, 0);
        vecs[10] = mk(1, 0, 0, 0, 0, 6, 1, 1, 0,  0, 0, 0, 0, 1, 1, 1, 1, 4, 1, 0);
        vecs[11] = mk(1, 6, 1, 0, 0, 7, 1, 0, 1,  0, 1, 0, 0, 0, 1, 1, 1, 5, 1, 1);
        vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 1, 6, 1, 1);

        // Reset state
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        chk_clear("reset");
        chk("reset stall", int'(stall), 0);
        chk("reset flush_id", int'(flush_id), 0);
        @(negedge clk);
        reset = 1'b0;

        // Table: forwarding, load-use stall, jump flush
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(vecs[i].v, vecs[i].s1, vecs[i].s1u, vecs[i].s2, vecs[i].s2u,
                  vecs[i].d, vecs[i].wb, vecs[i].mr, vecs[i].jmp);
            #2;
            chk($sformatf("v%0d stall", i), int'(stall), int'(vecs[i].e_stall));
            chk($sformatf("v%0d flush_id", i), int'(flush_id), int'(vecs[i].e_flush));
            tick();
            chk($sformatf("v%0d fwd1", i), int'(fwd1_sel), int'(vecs[i].e_f1));
            chk($sformatf("v%0d fwd2", i), int'(fwd2_sel), int'(vecs[i].e_f2));
            chk($sformatf("v%0d ex_valid", i), int'(ex_valid), int'(vecs[i].e_exv));
            chk($sformatf("v%0d mem_valid", i), int'(mem_valid), int'(vecs[i].e_memv));
            chk($sformatf("v%0d wb_valid", i), int'(wb_valid), int'(vecs[i].e_wbv));
            chk($sformatf("v%0d wb_en", i), int'(wb_en), int'(vecs[i].e_wben));
            chk($sformatf("v%0d wb_dst", i), int'(wb_dst), int'(vecs[i].e_wbdst));
            chk($sformatf("v%0d stall_count", i), int'(stall_count), vecs[i].e_sc);
            chk($sformatf("v%0d flush_count", i), int'(flush_count), vecs[i].e_fc);
        end

        // Reset with three writers in flight
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            drive(1, 0, 0, 0, 0, 3'(i), 1, 0, 0);
            tick();
        end
        chk("inflight ex_valid", int'(ex_valid), 1);
        chk("inflight mem_valid", int'(mem_valid), 1);
        chk("inflight wb_en", int'(wb_en), 1);
        @(negedge clk);
        reset = 1'b1;
        drive(1, 0, 0, 0, 0, 4, 1, 0, 0);
        tick();
        chk_clear("midreset");
        @(negedge clk);
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("postreset wb_en", int'(wb_en), 0);
        chk("postreset mem_valid", int'(mem_valid), 0);

        // Stall counter saturation: 20 load/consumer pairs
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive(1, 0, 0, 0, 0, 1, 1, 1, 0);
            tick();
            @(negedge clk);
            drive(1, 1, 1, 0, 0, 2, 1, 0, 0);
            #2;
            chk($sformatf("sat stall %0d", i), int'(stall), 1);
            tick();
            if (i == 14)
                chk("stall_count at 15", int'(stall_count), 15);
        end
        chk("stall_count saturated", int'(stall_count), 15);

        // Flush counter saturation: 20 jump cycles
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
            tick();
        end
        chk("flush_count saturated", int'(flush_count), 15);
        chk("stall_count held", int'(stall_count), 15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
